// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the
// requester IDs. A requester ID is also the MSB of the external tag, so
// responses can be routed back to the requester that issued them.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2
  } state_t;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

endpackage

// File: rtl/const.vh
// Shared memory-system widths used as parameter defaults by the arbiter.
//   MEM_ADDR_BITS  - line address width
//   MEM_DATA_BITS  - beat width
//   MEM_TAG_BITS   - external tag width (MSB selects the requester)
//   MEM_DATA_BEATS - write data beats per write request
`ifndef MEM_CONST_VH
`define MEM_CONST_VH

`define MEM_ADDR_BITS  28
`define MEM_DATA_BITS  128
`define MEM_TAG_BITS   5
`define MEM_DATA_BEATS 4

`endif

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick, purely combinational.
// Ports:
//   valid      in  [1:0]  request valids, indexed by requester ID
//   last_grant in  1      requester granted most recently
//   any_valid  out 1      at least one requester is asking
//   grant      out 1      chosen requester ID
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any_valid,
  output logic       grant
);

  assign any_valid = |valid;

  always_comb begin
    grant = GRANT_IC;
    if (valid[GRANT_DC] && valid[GRANT_IC]) begin
      // Tie: hand the slot to whoever did not get it last time.
      grant = ~last_grant;
    end else if (valid[GRANT_DC]) begin
      grant = GRANT_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the icache (read-only) and dcache (read/write) request
// channels onto one external memory port, and routes external responses
// back by the tag MSB.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   ic_req_* / ic_resp_*       icache read requests and responses
//   dc_req_* / dc_req_data_*   dcache requests and write data beats
//   dc_resp_*                  dcache responses
//   mem_req_* / mem_req_data_* external request and write data
//   mem_resp_*                 external response (no backpressure)
`include "const.vh"

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_BITS = `MEM_ADDR_BITS,
  parameter int MEM_DATA_BITS = `MEM_DATA_BITS,
  parameter int MEM_TAG_BITS  = `MEM_TAG_BITS,
  parameter int DATA_BEATS    = `MEM_DATA_BEATS
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       ic_req_valid,
  output logic                       ic_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
  input  logic [MEM_TAG_BITS-2:0]    ic_req_tag,
  output logic                       ic_resp_valid,
  output logic [MEM_TAG_BITS-2:0]    ic_resp_tag,
  output logic [MEM_DATA_BITS-1:0]   ic_resp_data,

  input  logic                       dc_req_valid,
  output logic                       dc_req_ready,
  input  logic                       dc_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic [MEM_TAG_BITS-2:0]    dc_req_tag,
  input  logic                       dc_req_data_valid,
  output logic                       dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                       dc_resp_valid,
  output logic [MEM_TAG_BITS-2:0]    dc_resp_tag,
  output logic [MEM_DATA_BITS-1:0]   dc_resp_data,

  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]    mem_req_tag,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,

  input  logic                       mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]    mem_resp_tag,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int BEAT_BITS = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(DATA_BEATS - 1);

  state_t               state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic                 last_grant_reg, last_grant_next;
  logic [BEAT_BITS-1:0] beat_cnt_reg, beat_cnt_next;

  logic arb_any;
  logic arb_grant;
  logic sel_rw;

  rr_arb2 u_rr_arb2 (
    .valid      ({dc_req_valid, ic_req_valid}),
    .last_grant (last_grant_reg),
    .any_valid  (arb_any),
    .grant      (arb_grant)
  );

  // The icache only reads, so only a dcache grant can carry a write.
  assign sel_rw = (grant_reg == GRANT_DC) && dc_req_rw;

  // Address and tag follow the registered grant; they are only qualified
  // by mem_req_valid, and stay stable through an ADDR stall because the
  // granted requester must hold its request.
  assign mem_req_addr = (grant_reg == GRANT_DC) ? dc_req_addr : ic_req_addr;
  assign mem_req_tag  = {grant_reg, (grant_reg == GRANT_DC) ? dc_req_tag : ic_req_tag};

  assign mem_req_data_bits = dc_req_data_bits;
  assign mem_req_data_mask = dc_req_data_mask;

  always_comb begin
    state_next         = state_reg;
    grant_next         = grant_reg;
    last_grant_next    = last_grant_reg;
    beat_cnt_next      = beat_cnt_reg;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    mem_req_data_valid = 1'b0;
    dc_req_data_ready  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          grant_next = arb_grant;
          state_next = ST_ADDR;
        end
      end

      ST_ADDR: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = sel_rw;
        ic_req_ready  = (grant_reg == GRANT_IC) && mem_req_ready;
        dc_req_ready  = (grant_reg == GRANT_DC) && mem_req_ready;
        if (mem_req_ready) begin
          last_grant_next = grant_reg;
          if (sel_rw) begin
            state_next    = ST_WDATA;
            beat_cnt_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_WDATA: begin
        mem_req_data_valid = dc_req_data_valid;
        dc_req_data_ready  = mem_req_data_ready;
        if (dc_req_data_valid && mem_req_data_ready) begin
          if (beat_cnt_reg == BEAT_LAST) begin
            state_next    = ST_IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + BEAT_BITS'(1);
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= GRANT_IC;
      last_grant_reg <= GRANT_IC;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  // Response routing is independent of the request FSM: the tag MSB picks
  // the requester, and the data bus is shared by both.
  assign ic_resp_valid = mem_resp_valid && !mem_resp_tag[MEM_TAG_BITS-1];
  assign dc_resp_valid = mem_resp_valid &&  mem_resp_tag[MEM_TAG_BITS-1];
  assign ic_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
  assign dc_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: response-routing vector table,
// request scoreboard, and hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int TW  = 5;
  localparam int RTW = 4;
  localparam int NB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            ic_req_valid, ic_req_ready;
  logic [AW-1:0]   ic_req_addr;
  logic [RTW-1:0]  ic_req_tag;
  logic            ic_resp_valid;
  logic [RTW-1:0]  ic_resp_tag;
  logic [DW-1:0]   ic_resp_data;
  logic            dc_req_valid, dc_req_ready, dc_req_rw;
  logic [AW-1:0]   dc_req_addr;
  logic [RTW-1:0]  dc_req_tag;
  logic            dc_req_data_valid, dc_req_data_ready;
  logic [DW-1:0]   dc_req_data_bits;
  logic [DW/8-1:0] dc_req_data_mask;
  logic            dc_resp_valid;
  logic [RTW-1:0]  dc_resp_tag;
  logic [DW-1:0]   dc_resp_data;
  logic            mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0]   mem_req_addr;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0]   mem_req_data_bits;
  logic [DW/8-1:0] mem_req_data_mask;
  logic            mem_resp_valid;
  logic [TW-1:0]   mem_resp_tag;
  logic [DW-1:0]   mem_resp_data;

  mem_arbiter #(
    .MEM_ADDR_BITS (AW),
    .MEM_DATA_BITS (DW),
    .MEM_TAG_BITS  (TW),
    .DATA_BEATS    (NB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ic_req_valid       (ic_req_valid),
    .ic_req_ready       (ic_req_ready),
    .ic_req_addr        (ic_req_addr),
    .ic_req_tag         (ic_req_tag),
    .ic_resp_valid      (ic_resp_valid),
    .ic_resp_tag        (ic_resp_tag),
    .ic_resp_data       (ic_resp_data),
    .dc_req_valid       (dc_req_valid),
    .dc_req_ready       (dc_req_ready),
    .dc_req_rw          (dc_req_rw),
    .dc_req_addr        (dc_req_addr),
    .dc_req_tag         (dc_req_tag),
    .dc_req_data_valid  (dc_req_data_valid),
    .dc_req_data_ready  (dc_req_data_ready),
    .dc_req_data_bits   (dc_req_data_bits),
    .dc_req_data_mask   (dc_req_data_mask),
    .dc_resp_valid      (dc_resp_valid),
    .dc_resp_tag        (dc_resp_tag),
    .dc_resp_data       (dc_resp_data),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_tag        (mem_req_tag),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_tag       (mem_resp_tag),
    .mem_resp_data      (mem_resp_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } req_exp_t;

  req_exp_t exp_q[$];
  req_exp_t mon_e;

  typedef struct {
    logic           valid;
    logic [TW-1:0]  tag;
    logic [DW-1:0]  data;
    logic           exp_ic;
    logic           exp_dc;
    logic [RTW-1:0] exp_tag;
  } resp_vec_t;

  resp_vec_t rtab[6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    req_exp_t e;
    e.rw = rw;
    e.addr = addr;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic ic_drive(input logic [AW-1:0] addr, input logic [RTW-1:0] tag);
    ic_req_valid = 1'b1;
    ic_req_addr  = addr;
    ic_req_tag   = tag;
  endtask

  task automatic dc_drive(input logic rw, input logic [AW-1:0] addr, input logic [RTW-1:0] tag);
    dc_req_valid = 1'b1;
    dc_req_rw    = rw;
    dc_req_addr  = addr;
    dc_req_tag   = tag;
  endtask

  // Bounded wait for an address handshake; returns in that ADDR cycle.
  task automatic wait_hs(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (mem_req_valid && mem_req_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no handshake expected one within 50 cycles", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    dc_req_data_valid = 1'b0;
    mem_req_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_data_valid", mem_req_data_valid, 1'b0);
    check("rst_ic_req_ready", ic_req_ready, 1'b0);
    check("rst_dc_req_ready", dc_req_ready, 1'b0);
    check("rst_dc_req_data_ready", dc_req_data_ready, 1'b0);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every address handshake pops one expectation.
  always @(negedge clk) begin
    #2;
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got tag %0h addr %0h expected no request", mem_req_tag, mem_req_addr);
      end else begin
        mon_e = exp_q.pop_front();
        $display("REQ rw=%0d addr=%07h tag=%02h", mem_req_rw, mem_req_addr, mem_req_tag);
        check("req_rw", mem_req_rw, mon_e.rw);
        check("req_addr", mem_req_addr, mon_e.addr);
        check("req_tag", mem_req_tag, mon_e.tag);
      end
    end
  end

  initial begin
    bit rp[7];
    logic [DW-1:0] beat;
    int accepted;

    rtab[0] = '{1'b1, 5'h03, {4{32'hA5A5_0003}}, 1'b1, 1'b0, 4'h3};
    rtab[1] = '{1'b1, 5'h1A, {4{32'h5A5A_001A}}, 1'b0, 1'b1, 4'hA};
    rtab[2] = '{1'b1, 5'h10, {4{32'h1234_0010}}, 1'b0, 1'b1, 4'h0};
    rtab[3] = '{1'b1, 5'h0F, {4{32'hCAFE_000F}}, 1'b1, 1'b0, 4'hF};
    rtab[4] = '{1'b0, 5'h1A, {4{32'hDEAD_BEEF}}, 1'b0, 1'b0, 4'hA};
    rtab[5] = '{1'b1, 5'h00, {4{32'h0000_0001}}, 1'b1, 1'b0, 4'h0};

    reset = 1'b1;
    ic_req_valid = 1'b0; ic_req_addr = '0; ic_req_tag = '0;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_tag = '0;
    dc_req_data_valid = 1'b0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;

    do_reset();

    // Response routing vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_resp_valid = rtab[i].valid;
      mem_resp_tag   = rtab[i].tag;
      mem_resp_data  = rtab[i].data;
      #1;
      $display("RESP vec=%0d tag=%02h ic_v=%0d dc_v=%0d", i, rtab[i].tag, ic_resp_valid, dc_resp_valid);
      check("resp_ic_valid", ic_resp_valid, rtab[i].exp_ic);
      check("resp_dc_valid", dc_resp_valid, rtab[i].exp_dc);
      if (rtab[i].exp_ic) check("resp_ic_tag", ic_resp_tag, rtab[i].exp_tag);
      if (rtab[i].exp_dc) check("resp_dc_tag", dc_resp_tag, rtab[i].exp_tag);
      check("resp_ic_data", ic_resp_data, rtab[i].data);
      check("resp_dc_data", dc_resp_data, rtab[i].data);
    end
    mem_resp_valid = 1'b0;

    // Single icache read: one-cycle arbitration latency.
    @(negedge clk);
    ic_drive(28'h0000100, 4'h3);
    push_exp(1'b0, 28'h0000100, 5'h03);
    #1;
    check("ic_rd_idle_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    #1;
    check("ic_rd_addr_valid", mem_req_valid, 1'b1);
    check("ic_rd_ic_ready", ic_req_ready, 1'b1);
    check("ic_rd_dc_ready", dc_req_ready, 1'b0);
    @(negedge clk);
    ic_req_valid = 1'b0;
    #1;
    check("ic_rd_back_idle", mem_req_valid, 1'b0);

    // ADDR stall for 10 cycles, with a dcache response arriving mid-stall.
    @(negedge clk);
    mem_req_ready = 1'b0;
    ic_drive(28'h0ABCDE0, 4'h9);
    push_exp(1'b0, 28'h0ABCDE0, 5'h09);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("stall_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_req_addr, 28'h0ABCDE0);
      check("stall_tag", mem_req_tag, 5'h09);
      check("stall_ic_ready", ic_req_ready, 1'b0);
      if (c == 3) begin
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'h1A;
        mem_resp_data  = {4{32'h0BAD_F00D}};
        #1;
        check("stall_resp_dc_valid", dc_resp_valid, 1'b1);
        check("stall_resp_dc_tag", dc_resp_tag, 4'hA);
        check("stall_resp_ic_valid", ic_resp_valid, 1'b0);
        mem_resp_valid = 1'b0;
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    check("stall_release_ic_ready", ic_req_ready, 1'b1);
    @(negedge clk);
    ic_req_valid = 1'b0;

    // Round-robin with both reads held from just after reset.
    do_reset();
    @(negedge clk);
    ic_drive(28'h0000111, 4'h1);
    dc_drive(1'b0, 28'h0000222, 4'h2);
    push_exp(1'b0, 28'h0000222, 5'h12);
    push_exp(1'b0, 28'h0000111, 5'h01);
    push_exp(1'b0, 28'h0000222, 5'h12);
    push_exp(1'b0, 28'h0000111, 5'h01);
    for (int n = 0; n < 4; n++) wait_hs("rr");
    @(negedge clk);
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;

    // dcache write with a 3-cycle data stall while icache waits.
    @(negedge clk);
    dc_drive(1'b1, 28'h0000200, 4'h5);
    ic_drive(28'h0000300, 4'h7);
    push_exp(1'b1, 28'h0000200, 5'h15);
    push_exp(1'b0, 28'h0000300, 5'h07);
    wait_hs("dc_write_addr");
    rp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dc_req_valid = 1'b0;
      beat = {4{32'hD000_0000 + 32'(accepted)}};
      dc_req_data_valid = 1'b1;
      dc_req_data_bits  = beat;
      dc_req_data_mask  = 16'hFFFF;
      mem_req_data_ready = rp[i];
      #1;
      $display("BEAT cyc=%0d accepted=%0d ready=%0d", i, accepted, rp[i]);
      check("wr_data_valid", mem_req_data_valid, 1'b1);
      check("wr_data_bits", mem_req_data_bits, beat);
      check("wr_data_mask", mem_req_data_mask, 16'hFFFF);
      check("wr_data_ready", dc_req_data_ready, rp[i]);
      check("wr_ic_ready_blocked", ic_req_ready, 1'b0);
      check("wr_no_mem_req", mem_req_valid, 1'b0);
      if (rp[i]) accepted++;
    end
    @(negedge clk);
    #1;
    check("wr_done_data_valid", mem_req_data_valid, 1'b0);
    check("wr_done_data_ready", dc_req_data_ready, 1'b0);
    check("wr_done_idle", mem_req_valid, 1'b0);
    dc_req_data_valid = 1'b0;
    mem_req_data_ready = 1'b0;
    @(negedge clk);
    #1;
    check("wr_then_ic_valid", mem_req_valid, 1'b1);
    check("wr_then_ic_ready", ic_req_ready, 1'b1);
    @(negedge clk);
    ic_req_valid = 1'b0;

    // Reset after 2 of 4 beats abandons the burst.
    @(negedge clk);
    dc_drive(1'b1, 28'h0000400, 4'hB);
    push_exp(1'b1, 28'h0000400, 5'h1B);
    wait_hs("abort_write_addr");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dc_req_valid = 1'b0;
      dc_req_data_valid = 1'b1;
      mem_req_data_ready = 1'b1;
      #1;
      check("abort_beat_valid", mem_req_data_valid, 1'b1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_data_valid", mem_req_data_valid, 1'b0);
    check("abort_data_ready", dc_req_data_ready, 1'b0);
    check("abort_mem_valid", mem_req_valid, 1'b0);
    reset = 1'b0;
    dc_req_data_valid = 1'b0;
    @(negedge clk);
    dc_drive(1'b1, 28'h0000500, 4'hC);
    push_exp(1'b1, 28'h0000500, 5'h1C);
    wait_hs("fresh_write_addr");
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      dc_req_valid = 1'b0;
      dc_req_data_valid = 1'b1;
      mem_req_data_ready = 1'b1;
      #1;
      check("fresh_beat_valid", mem_req_data_valid, 1'b1);
    end
    @(negedge clk);
    #1;
    check("fresh_done_data_valid", mem_req_data_valid, 1'b0);
    dc_req_data_valid = 1'b0;
    mem_req_data_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
